// File: rtl/cic_interp.sv
// rtl/cic_interp.sv - 5-stage CIC interpolator: combs at strobe rate, zero-stuff by R, integrators at clk rate.
module cic_interp #(
  parameter int WIDTH = 80
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       interp_ratio,
  input  logic [6:0]        out_shift,
  input  logic signed [7:0] d_in,
  output logic              in_stb,
  output logic signed [15:0] d_out,
  output logic              out_valid
);

  localparam logic signed [WIDTH-1:0] SAT_HI = {{(WIDTH-16){1'b0}}, 16'h7fff};
  localparam logic signed [WIDTH-1:0] SAT_LO = {{(WIDTH-16){1'b1}}, 16'h8000};

  logic [15:0]              count_q, count_d;
  logic [15:0]              ratio_m1;
  logic                     wrap;
  logic                     stuff_q, stuff_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [15:0]       d_out_q, d_out_d;
  logic signed [WIDTH-1:0]  c_q   [1:5];
  logic signed [WIDTH-1:0]  c_d   [1:5];
  logic signed [WIDTH-1:0]  dly_q [1:5];
  logic signed [WIDTH-1:0]  dly_d [1:5];
  logic signed [WIDTH-1:0]  integ_q [1:5];
  logic signed [WIDTH-1:0]  integ_d [1:5];
  logic signed [WIDTH-1:0]  comb_in;
  logic signed [WIDTH-1:0]  shifted;

  // A programmed ratio of 0 behaves as 1, so the wrap point is 0 in both cases.
  assign ratio_m1 = (interp_ratio == 16'd0) ? 16'd0 : interp_ratio - 16'd1;
  assign wrap     = (count_q >= ratio_m1);
  assign in_stb   = wrap && !rst;
  assign shifted  = integ_q[5] >>> out_shift;

  always_comb begin
    count_d     = wrap ? 16'd0 : count_q + 16'd1;
    stuff_d     = in_stb;
    out_valid_d = 1'b1;
    comb_in     = '0;

    for (int k = 1; k <= 5; k++) begin
      c_d[k]   = c_q[k];
      dly_d[k] = dly_q[k];
      if (in_stb) begin
        comb_in  = (k == 1) ? {{(WIDTH-8){d_in[7]}}, d_in} : c_q[k-1];
        c_d[k]   = comb_in - dly_q[k];
        dly_d[k] = comb_in;
      end
    end

    // Zero-stuffing: the first integrator only sees c_5 in the cycle after a capture.
    integ_d[1] = stuff_q ? integ_q[1] + c_q[5] : integ_q[1];
    for (int k = 2; k <= 5; k++) begin
      integ_d[k] = integ_q[k] + integ_q[k-1];
    end

    if (shifted > SAT_HI) begin
      d_out_d = 16'sh7fff;
    end else if (shifted < SAT_LO) begin
      d_out_d = -16'sh8000;
    end else begin
      d_out_d = shifted[15:0];
    end

    if (rst) begin
      count_d     = '0;
      stuff_d     = 1'b0;
      out_valid_d = 1'b0;
      d_out_d     = '0;
      for (int k = 1; k <= 5; k++) begin
        c_d[k]     = '0;
        dly_d[k]   = '0;
        integ_d[k] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    count_q     <= count_d;
    stuff_q     <= stuff_d;
    out_valid_q <= out_valid_d;
    d_out_q     <= d_out_d;
    for (int k = 1; k <= 5; k++) begin
      c_q[k]     <= c_d[k];
      dly_q[k]   <= dly_d[k];
      integ_q[k] <= integ_d[k];
    end
  end

  assign d_out     = d_out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cic_interp.sv
// tb/tb_cic_interp.sv - randomized scoreboard bench for cic_interp against a closed-form CIC model.
module tb_cic_interp;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [15:0]       interp_ratio = 16'd1;
  logic [6:0]        out_shift = 7'd0;
  logic signed [7:0] d_in = 8'sd0;
  logic              in_stb;
  logic signed [15:0] d_out;
  logic              out_valid;

  cic_interp #(.WIDTH(80)) dut (
    .clk          (clk),
    .rst          (rst),
    .interp_ratio (interp_ratio),
    .out_shift    (out_shift),
    .d_in         (d_in),
    .in_stb       (in_stb),
    .d_out        (d_out),
    .out_valid    (out_valid)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  int cyc = 0;
  int r_eff = 1;
  int sh = 0;
  int xs[$];
  int din_log[$];
  longint imp_e[$];
  logic signed [127:0] imp_v[$];
  longint q_d[$];
  bit q_s[$];
  int bc[6] = '{1, -5, 10, -10, 5, -1};

  task automatic chk(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
  endtask

  function automatic logic signed [127:0] c4(input longint n);
    logic signed [127:0] v;
    if (n < 4) return 0;
    v = n;
    return (v * (v - 1) * (v - 2) * (v - 3)) / 24;
  endfunction

  // Output in cycle c: each impulse a entering the integrator chain at edge e
  // contributes a*C(c-1-e,4) to the last integrator, then shift and saturate.
  function automatic longint model_out(input int c);
    logic signed [127:0] acc;
    acc = 0;
    for (int i = 0; i < imp_e.size(); i++) acc = acc + imp_v[i] * c4(c - 1 - imp_e[i]);
    acc = acc >>> sh;
    if (acc > 32767) return 32767;
    if (acc < -32768) return -32768;
    return longint'(acc);
  endfunction

  task automatic step(input int din);
    logic signed [127:0] a;
    int m;
    d_in = din[7:0];
    din_log.push_back(din);
    if (cyc >= 1) begin
      q_d.push_back(model_out(cyc));
      q_s.push_back(((cyc + 1) % r_eff) == 0);
    end
    if (((cyc + 1) % r_eff) == 0) begin
      xs.push_back(din);
      m = xs.size() - 1;
      if (m >= 4) begin
        a = 0;
        for (int j = 0; j <= 5; j++)
          if (m - 4 - j >= 0) a = a + bc[j] * xs[m - 4 - j];
        if (a != 0) begin
          imp_e.push_back(cyc + 2);
          imp_v.push_back(a);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int r, input int s);
    chk("sb_drained", q_d.size(), 0);
    interp_ratio = r[15:0];
    out_shift = s[6:0];
    d_in = 8'sd0;
    rst = 1'b1;
    #1;
    chk("in_stb_during_rst", in_stb, 0);
    @(posedge clk);
    #1;
    chk("rst_d_out", d_out, 0);
    chk("rst_out_valid", out_valid, 0);
    rst = 1'b0;
    #1;
    chk("rel_out_valid", out_valid, 0);
    chk("rel_d_out", d_out, 0);
    chk("rel_in_stb", in_stb, (r <= 1) ? 1 : 0);
    cyc = 0;
    r_eff = (r == 0) ? 1 : r;
    sh = s;
    xs.delete();
    din_log.delete();
    imp_e.delete();
    imp_v.delete();
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1) begin
      if (q_d.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        chk("d_out", d_out, q_d.pop_front());
        chk("in_stb", in_stb, q_s.pop_front());
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;

    do_reset(1, 0);
    step(1);
    repeat (30) step(0);

    do_reset(5, 0);
    repeat (60) step(0);
    chk("zero_hold", d_out, 0);

    do_reset(4, 0);
    repeat (150) step(1);
    chk("r4_dc1", d_out, 256);

    do_reset(4, 0);
    repeat (150) step(-128);
    chk("r4_neg_full", d_out, -32768);
    repeat (150) step(127);
    chk("r4_pos_full", d_out, 32512);

    do_reset(8, 0);
    repeat (200) step(100);
    chk("r8_sat", d_out, 32767);

    do_reset(8, 4);
    repeat (200) step(100);
    chk("r8_shift4", d_out, 25600);

    do_reset(0, 0);
    repeat (200) step(int'($urandom_range(255)) - 128);
    chk("r0_passthru", d_out, din_log[cyc - 11]);

    do_reset(3, 3);
    repeat (200) step(int'($urandom_range(255)) - 128);

    do_reset(4, 0);
    repeat (100) step(1);
    do_reset(4, 0);
    repeat (150) step(1);
    chk("post_pulse_dc", d_out, 256);

    chk("sb_final_drained", q_d.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cic_interp.md
CIC_INTERP -- requirements
Module: cic_interp

Interface
REQ-001 Parameter: WIDTH, 80, signed width of every comb and integrator register; SHALL be >= 8 + 4*ceil(log2(interp_ratio)).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset rst, synchronous, active-high.
REQ-004 interp_ratio  input  16  unsigned interpolation factor R; value 0 SHALL be treated as 1.
REQ-005 out_shift  input  7  arithmetic right-shift applied to the last integrator before saturation (0..WIDTH-1).
REQ-006 d_in  input  8  signed low-rate sample, captured on the rising edge that ends a cycle with in_stb high.
REQ-007 in_stb  output  1  request/capture strobe, high one cycle in every R cycles (every cycle when R=1).
REQ-008 d_out  output  16  signed high-rate sample, updated every clk.
REQ-009 out_valid  output  1  high every cycle d_out carries filter output.

Function
REQ-010 Filter SHALL be 5-stage CIC interpolator, differential delay 1: 5 combs at input rate, zero-stuff by R, 5 integrators at clk rate.
REQ-011 Phase counter count (16 bit) SHALL increment each clk and load 0 on the edge where count >= R-1.
REQ-012 in_stb SHALL be decoded as (count >= R-1) and forced 0 while rst high.
REQ-013 interp_ratio change SHALL take effect immediately via the >= compare; no glitch beyond one shortened or lengthened period.
REQ-014 Comb k (k=1..5) SHALL register, only on in_stb edges: c_k <= x_k - x_k_dly and x_k_dly <= x_k, where x_1 = sign-extended d_in and x_k = c_(k-1).
REQ-015 Comb registers and delays SHALL hold between strobes.
REQ-016 Stuff flag stuff_v SHALL be registered in_stb (high the cycle after each capture edge).
REQ-017 Integrator 1 SHALL add c_5 when stuff_v high and 0 otherwise; integrator k (k=2..5) SHALL add integrator k-1 every clk.
REQ-018 All arithmetic SHALL be WIDTH-bit two's complement, wrap-around, no internal saturation.
REQ-019 d_out SHALL register sat16(i_5 >>> out_shift): values > 32767 give 32767, < -32768 give -32768.
REQ-020 DC gain before shift SHALL be R^4.
REQ-021 Latency: sample captured at edge n SHALL first influence d_out after edge n+10 (R=1: exact pass-through, d_out = d_in delayed 10 edges after capture).
REQ-022 out_valid SHALL go high on the first edge after rst deasserts and stay high.

Reset
REQ-023 While rst high on an edge: count, all comb, delay, integrator registers, stuff_v, d_out SHALL load 0; out_valid SHALL load 0.
REQ-024 rst asserted mid-operation SHALL take effect on that edge regardless of count or stuff phase; first in_stb SHALL occur in cycle R-1 after release (cycle 0 when R=1).
REQ-025 After reset, with d_in held 0, d_out SHALL remain 0 indefinitely.

Verification
REQ-026 R=1, out_shift=0, single impulse d_in=1 at one capture then 0 -> d_out=1 for exactly one cycle, 10 edges after capture; 0 otherwise.
REQ-027 R=4, out_shift=0, d_in=1 constant -> in_stb every 4th cycle; d_out settles to 256 and holds.
REQ-028 R=4, out_shift=0, d_in=-128 constant -> d_out settles to -32768, no wrap; d_in=127 -> 32512.
REQ-029 R=8, d_in=100 constant: out_shift=0 -> d_out saturates at 32767; out_shift=4 -> settles to 25600.
REQ-030 R=0 programmed -> behaves identically to R=1 (in_stb constantly high, pass-through).
REQ-031 Mid-stream rst pulse (one cycle, R=4, d_in=1) -> next cycle all outputs 0, in_stb first re-asserts in cycle 3 after release, d_out re-settles to 256.
